// File: rtl/state_addsub_pipe.sv
// Streaming add/sub/saturating ALU: two independently handshaked operand slots,
// a STAGES-deep valid/ready result pipeline and a delivered-result counter.

module state_addsub_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic         up_vld,
  input  logic [W-1:0] up_dat,
  output logic         vld,
  output logic [W-1:0] dat
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (load_en) begin
      vld <= up_vld;
      if (up_vld) dat <= up_dat;
    end
  end
endmodule

module state_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] state__A,
  input  logic [1:0]       state__A_op,
  input  logic             state__A_vld,
  output logic             state__A_rdy,
  input  logic [WIDTH-1:0] state__B,
  input  logic             state__B_vld,
  output logic             state__B_rdy,
  output logic [WIDTH-1:0] state__C,
  output logic             state__C_ovf,
  output logic             state__C_vld,
  input  logic             state__C_rdy,
  output logic [CNT_W-1:0] state__C_cnt
);
  typedef struct packed {
    logic             ovf;
    logic [WIDTH-1:0] res;
  } result_t;

  logic             a_v, b_v;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic             fire, a_load, b_load;
  logic [WIDTH:0]   sum, diff;
  result_t          alu;

  logic    [STAGES:1] vld_pipe;
  result_t [STAGES:1] dat_pipe;
  logic    [STAGES:1] load_en;

  assign fire   = a_v & b_v & load_en[1];
  assign a_load = state__A_vld & (fire | ~a_v);
  assign b_load = state__B_vld & (fire | ~b_v);
  assign state__A_rdy = a_load;
  assign state__B_rdy = b_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_v  <= 1'b0;
      b_v  <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else begin
      if (fire | ~a_v) a_v <= state__A_vld;
      if (fire | ~b_v) b_v <= state__B_vld;
      if (a_load) begin
        a_q  <= state__A;
        op_q <= state__A_op;
      end
      if (b_load) b_q <= state__B;
    end
  end

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu = '0;
    case (op_q)
      2'b00: begin
        alu.res = sum[WIDTH-1:0];
        alu.ovf = sum[WIDTH];
      end
      2'b01: begin
        alu.res = diff[WIDTH-1:0];
        alu.ovf = diff[WIDTH];
      end
      2'b10: begin
        alu.res = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        alu.ovf = sum[WIDTH];
      end
      default: begin
        // Signed overflow: operands agree in sign but the sum does not.
        if ((a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1])) begin
          alu.res = {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};
          alu.ovf = 1'b1;
        end else begin
          alu.res = sum[WIDTH-1:0];
        end
      end
    endcase
  end

  // Each stage can load when C is taken or any slot at or after it is empty,
  // flattened so the enables depend only on registers and C_rdy.
  for (genvar i = 1; i <= STAGES; i++) begin : g_stage
    logic    up_vld;
    result_t up_dat;
    if (i == 1) begin : g_first
      assign up_vld = fire;
      assign up_dat = alu;
    end else begin : g_next
      assign up_vld = vld_pipe[i-1];
      assign up_dat = dat_pipe[i-1];
    end
    assign load_en[i] = state__C_rdy | ~(&vld_pipe[STAGES:i]);

    state_addsub_stage #(.W(WIDTH + 1)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .load_en(load_en[i]),
      .up_vld (up_vld),
      .up_dat (up_dat),
      .vld    (vld_pipe[i]),
      .dat    (dat_pipe[i])
    );
  end

  assign state__C     = dat_pipe[STAGES].res;
  assign state__C_ovf = dat_pipe[STAGES].ovf;
  assign state__C_vld = vld_pipe[STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state__C_cnt <= '0;
    else if (state__C_vld & state__C_rdy) state__C_cnt <= state__C_cnt + 1'b1;
  end
endmodule

// File: tb/tb_state_addsub_pipe.sv
// Bench for state_addsub_pipe (WIDTH=8, STAGES=2): directed vector table, corner
// sequences and randomized traffic checked against an operand-pairing scoreboard.

module tb_state_addsub_pipe;
  localparam int W = 8, S = 2, CW = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] A, B, C;
  logic [1:0]   A_op;
  logic A_vld, A_rdy, B_vld, B_rdy, C_ovf, C_vld, C_rdy;
  logic [CW-1:0] C_cnt;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  state_addsub_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .state__A(A), .state__A_op(A_op), .state__A_vld(A_vld), .state__A_rdy(A_rdy),
    .state__B(B), .state__B_vld(B_vld), .state__B_rdy(B_rdy),
    .state__C(C), .state__C_ovf(C_ovf), .state__C_vld(C_vld), .state__C_rdy(C_rdy),
    .state__C_cnt(C_cnt)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] a, b, c;
    logic       ovf;
  } vec_t;
  vec_t tbl[7];

  logic [9:0]  a_q[$];
  logic [7:0]  b_q[$];
  logic [8:0]  exp_q[$];
  logic [15:0] model_cnt;
  logic [7:0]  va[256], vb[256];
  logic [1:0]  vop[256];
  int cyc = 0, first_d, last_d;
  logic hold_v = 1'b0;
  logic [8:0] hold_d;
  bit stop_tog;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: result from integer arithmetic on the operand values.
  function automatic logic [8:0] ref_calc(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    int s, sa, sb;
    case (op)
      2'd0: begin s = int'(a) + int'(b); return {1'(s > 255), 8'(s)}; end
      2'd1: begin s = int'(a) - int'(b); return {1'(s < 0), 8'(s)}; end
      2'd2: begin s = int'(a) + int'(b); return (s > 255) ? 9'h1FF : {1'b0, 8'(s)}; end
      default: begin
        sa = (a > 127) ? int'(a) - 256 : int'(a);
        sb = (b > 127) ? int'(b) - 256 : int'(b);
        s  = sa + sb;
        if (s > 127)  return 9'h17F;
        if (s < -128) return 9'h180;
        return {1'b0, 8'(s)};
      end
    endcase
  endfunction

  // Scoreboard: n-th accepted A pairs with n-th accepted B; results leave in order.
  always @(negedge clk) begin
    logic [9:0] ea;
    logic [7:0] eb;
    logic [8:0] e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      cyc++;
      if (hold_v) begin
        chk("c_hold_vld", int'(C_vld), 1);
        chk("c_hold_data", int'({C_ovf, C}), int'(hold_d));
      end
      if (C_vld && C_rdy) begin
        if (exp_q.size() == 0) chk("c_spurious_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("c_result", int'({C_ovf, C}), int'(e));
        end
        chk("c_cnt_running", int'(C_cnt), int'(model_cnt));
        model_cnt = model_cnt + 16'd1;
        if (first_d < 0) first_d = cyc;
        last_d = cyc;
      end
      hold_v = C_vld && !C_rdy;
      hold_d = {C_ovf, C};
      if (A_vld && A_rdy) a_q.push_back({A_op, A});
      if (B_vld && B_rdy) b_q.push_back(B);
      while (a_q.size() > 0 && b_q.size() > 0) begin
        ea = a_q.pop_front();
        eb = b_q.pop_front();
        exp_q.push_back(ref_calc(ea[9:8], ea[7:0], eb));
      end
    end
  end

  task automatic flush_model();
    a_q.delete(); b_q.delete(); exp_q.delete();
    model_cnt = 16'd0;
  endtask

  task automatic present(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bit ad = 0, bd = 0;
    @(posedge clk); #1;
    A = a; A_op = op; B = b; A_vld = 1'b1; B_vld = 1'b1;
    while (!(ad && bd) && n < 50) begin
      @(negedge clk); n++;
      if (A_rdy) ad = 1;
      if (B_rdy) bd = 1;
      @(posedge clk); #1;
      if (ad) A_vld = 1'b0;
      if (bd) B_vld = 1'b0;
    end
    if (!(ad && bd)) chk("pair_accept_timeout", 0, 1);
    A_vld = 1'b0; B_vld = 1'b0;
  endtask

  task automatic send_check(input vec_t v, input string nm, input int exp_cnt);
    int n = 0;
    present(v.op, v.a, v.b);
    do begin @(negedge clk); n++; end while (!C_vld && n < 20);
    chk({nm, "_latency"}, n, 3);
    chk({nm, "_c"}, int'(C), int'(v.c));
    chk({nm, "_ovf"}, int'(C_ovf), int'(v.ovf));
    @(posedge clk); #1;
    chk({nm, "_cnt"}, int'(C_cnt), exp_cnt);
  endtask

  task automatic run_a(input int n, input int idle_pct);
    int g;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < idle_pct) begin A_vld = 1'b0; @(posedge clk); #1; end
      A = va[i]; A_op = vop[i]; A_vld = 1'b1;
      g = 0;
      do begin @(negedge clk); g++; end while (!A_rdy && g < 200);
      if (!A_rdy) chk("a_accept_timeout", 0, 1);
      @(posedge clk); #1;
    end
    A_vld = 1'b0;
  endtask

  task automatic run_b(input int n, input int idle_pct);
    int g;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < idle_pct) begin B_vld = 1'b0; @(posedge clk); #1; end
      B = vb[i]; B_vld = 1'b1;
      g = 0;
      do begin @(negedge clk); g++; end while (!B_rdy && g < 200);
      if (!B_rdy) chk("b_accept_timeout", 0, 1);
      @(posedge clk); #1;
    end
    B_vld = 1'b0;
  endtask

  task automatic rdy_driver(input int mode);
    int k = 0;
    while (!stop_tog) begin
      if (mode == 0) C_rdy = (k % 4 == 0) || (k % 4 == 3);
      else           C_rdy = 1'($urandom_range(1));
      k++;
      @(posedge clk); #1;
    end
    C_rdy = 1'b1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() > 0 || a_q.size() > 0 || b_q.size() > 0) && n < 1000) begin
      @(negedge clk); n++;
    end
    chk({nm, "_drained"}, int'(n < 1000), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    flush_model();
    @(posedge clk); #3;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses, cv;
    A = '0; B = '0; A_op = '0; A_vld = 1'b0; B_vld = 1'b0; C_rdy = 1'b1;
    model_cnt = 16'd0; first_d = -1; last_d = -1; stop_tog = 0;
    tbl[0] = '{2'd0, 8'h05, 8'h03, 8'h08, 1'b0};
    tbl[1] = '{2'd0, 8'hFF, 8'h02, 8'h01, 1'b1};
    tbl[2] = '{2'd1, 8'h02, 8'h05, 8'hFD, 1'b1};
    tbl[3] = '{2'd2, 8'hF0, 8'h20, 8'hFF, 1'b1};
    tbl[4] = '{2'd3, 8'h70, 8'h20, 8'h7F, 1'b1};
    tbl[5] = '{2'd3, 8'h90, 8'hE0, 8'h80, 1'b1};
    tbl[6] = '{2'd3, 8'h10, 8'hF0, 8'h00, 1'b0};

    // Reset state and combinational rdy while held in reset
    #2;
    chk("rst_c", int'(C), 0);
    chk("rst_ovf", int'(C_ovf), 0);
    chk("rst_vld", int'(C_vld), 0);
    chk("rst_cnt", int'(C_cnt), 0);
    A_vld = 1'b1; #1 chk("rst_a_rdy_follows", int'(A_rdy), 1);
    B_vld = 1'b1; #1 chk("rst_b_rdy_follows", int'(B_rdy), 1);
    A_vld = 1'b0; B_vld = 1'b0; #1 chk("rst_a_rdy_low", int'(A_rdy), 0);
    @(posedge clk); @(posedge clk); #3 rst = 1'b0;

    for (int i = 0; i < 7; i++) send_check(tbl[i], $sformatf("tbl%0d", i), i + 1);

    // Async reset with two results in flight
    C_rdy = 1'b0;
    present(2'd0, 8'h11, 8'h22);
    present(2'd0, 8'h01, 8'h02);
    repeat (3) @(posedge clk);
    #1 chk("inflight_vld", int'(C_vld), 1);
    chk("inflight_cnt", int'(C_cnt), 7);
    #2 rst = 1'b1;
    flush_model();
    #1;
    chk("async_rst_vld", int'(C_vld), 0);
    chk("async_rst_cnt", int'(C_cnt), 0);
    chk("async_rst_c", int'(C), 0);
    @(posedge clk); #3 rst = 1'b0;
    C_rdy = 1'b1;
    send_check('{2'd0, 8'h01, 8'h01, 8'h02, 1'b0}, "post_rst", 1);

    // Full-rate stream (i, 2i)
    do_reset();
    for (int i = 0; i < 10; i++) begin
      va[i] = 8'(i + 1); vb[i] = 8'(2 * (i + 1)); vop[i] = 2'd0;
    end
    first_d = -1;
    fork run_a(10, 0); run_b(10, 0); join
    drain("stream1");
    chk("stream1_span", last_d - first_d, 9);
    @(posedge clk); #1 chk("stream1_cnt", int'(C_cnt), 10);

    // Same stream under C_rdy 1,0,0,1
    stop_tog = 0;
    fork
      begin
        fork run_a(10, 0); run_b(10, 0); join
        drain("stream2");
        stop_tog = 1;
      end
      rdy_driver(0);
    join
    @(posedge clk); #1 chk("stream2_cnt", int'(C_cnt), 20);

    // Lone A never fires; B then completes exactly one result
    @(posedge clk); #1;
    A = 8'h33; A_op = 2'd0; A_vld = 1'b1; B_vld = 1'b0;
    pulses = 0; cv = 0;
    repeat (5) begin
      @(negedge clk); pulses += int'(A_rdy); cv += int'(C_vld);
      @(posedge clk); #1;
    end
    A_vld = 1'b0;
    chk("lone_a_pulses", pulses, 1);
    chk("lone_a_no_result", cv, 0);
    B = 8'h11; B_vld = 1'b1;
    @(negedge clk); chk("b_completes_rdy", int'(B_rdy), 1);
    @(posedge clk); #1 B_vld = 1'b0;
    cv = 0;
    repeat (6) begin @(negedge clk); cv += int'(C_vld); end
    chk("lone_a_one_result", cv, 1);
    @(posedge clk); #1 chk("lone_a_cnt", int'(C_cnt), 21);

    // Randomized traffic, idle gaps and backpressure
    for (int i = 0; i < 200; i++) begin
      va[i] = 8'($urandom); vb[i] = 8'($urandom); vop[i] = 2'($urandom);
    end
    stop_tog = 0;
    fork
      begin
        fork run_a(200, 30); run_b(200, 30); join
        drain("random");
        stop_tog = 1;
      end
      rdy_driver(1);
    join
    @(posedge clk); #1 chk("random_cnt", int'(C_cnt), 221);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/state_addsub_pipe.md
Name: state_addsub_pipe

Overview:
Parametrised successor to the single-stage two-operand adder in the streaming state datapath.
- Two independently handshaked operand channels (A with opcode, B) feed a selectable add/sub/saturating ALU.
- The result passes through a configurable-depth valid/ready output pipeline with per-result overflow flag.
- A running count of delivered results is kept for performance monitoring.

Parameters:
WIDTH, 32, operand and result width in bits (>=2)
STAGES, 1, number of output register slices after the compute point (>=1)
CNT_W, 16, width of delivered-result counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high; clears all state immediately
state__A  input  WIDTH  operand a
state__A_op  input  2  opcode travelling with a
state__A_vld  input  1  A channel valid
state__A_rdy  output  1  A channel accepted this cycle
state__B  input  WIDTH  operand b
state__B_vld  input  1  B channel valid
state__B_rdy  output  1  B channel accepted this cycle
state__C  output  WIDTH  result
state__C_ovf  output  1  overflow/saturation flag for state__C
state__C_vld  output  1  result valid
state__C_rdy  input  1  downstream ready
state__C_cnt  output  CNT_W  number of results delivered (C_vld & C_rdy) since reset

Behaviour:
- Input slots: one holding register plus valid bit each for A (data+op) and B; the two channels are independent.
- fire = A_valid_reg & B_valid_reg & stage1_load_en. On fire both slots are consumed.
- Slot X load_en = X_vld & (fire | ~X_valid_reg); X_rdy = X_load_en. rdy is asserted only in the cycle data is actually captured.
- Slot valid reg updates to X_vld whenever (fire | ~X_valid_reg).
- Compute is combinational from the slot registers. op encoding:
  - 00: a+b, wrap; ovf = carry out.
  - 01: a-b, wrap; ovf = borrow (a<b unsigned).
  - 10: unsigned saturating add; on carry, result = all ones and ovf=1.
  - 11: signed saturating add; on signed overflow, result = max positive (0x7F..F) or min negative (0x80..0) by sign of a, and ovf=1.
  - Otherwise ovf=0.
- Output pipeline, stages 1..STAGES:
  - Each stage has data (WIDTH+1 incl. ovf) and valid.
  - Stage i load_en = downstream_ready_i | ~valid_i, where downstream_ready for the last stage is C_rdy and for stage i is stage i+1 load_en.
  - When load_en, valid_i <= upstream valid (fire for stage 1) and data loads only if upstream valid.
  - C/C_ovf/C_vld come directly from the last stage.
- Latency: A and B both captured at edge t -> fire possible in cycle t+1 -> C_vld asserted after edge t+1+STAGES-1, i.e. result visible STAGES cycles after the operands become slot-valid.
- Throughput: one result per cycle with C_rdy held high and inputs streaming.
- Backpressure:
  - C_rdy=0 with all stages full: no fire; slots hold; A_rdy/B_rdy=0 for any occupied slot.
  - C_vld and C data stay stable until accepted.
  - No data loss or duplication.
- Missing operand: one channel valid alone never fires; its slot holds indefinitely, and the other channel stays ready until the slot fills.
- Counter: C_cnt increments by 1 on each cycle with C_vld & C_rdy; wraps modulo 2^CNT_W.
- Reset: asynchronous assertion clears all valid bits, data registers, ovf and counter to 0 immediately, mid-transfer included. Outputs during/after reset:
  - C=0, C_ovf=0, C_vld=0, C_cnt=0.
  - A_rdy/B_rdy follow their vld inputs combinationally (slots are empty) but no capture occurs while rst=1.
- In-flight data is discarded by reset; after deassertion the first operands accepted produce the first result.

Test Plan:
- WIDTH=8, STAGES=2, C_rdy=1: A=0x05 op=00, B=0x03 presented together -> C=0x08, ovf=0 exactly 2 cycles after capture; C_cnt=1 after accept.
- op=00, A=0xFF, B=0x02 -> C=0x01, ovf=1. op=01, A=0x02, B=0x05 -> C=0xFD, ovf=1. op=10, A=0xF0, B=0x20 -> C=0xFF, ovf=1.
- op=11: A=0x70, B=0x20 -> C=0x7F, ovf=1. A=0x90, B=0xE0 -> C=0x80, ovf=1. A=0x10, B=0xF0 -> C=0x00, ovf=0.
- Stream 10 pairs (i, 2i) with C_rdy=1 -> 10 consecutive C_vld cycles, results 3i in order, C_cnt=10. Then repeat with C_rdy toggling 1,0,0,1 -> same ordered results, C held stable while C_rdy=0, no drops.
- A_vld held high for 5 cycles with B_vld=0 -> one A capture (A_rdy pulses once), no C_vld. Then B_vld=1 for one cycle -> exactly one result.
- Assert rst asynchronously mid-cycle with 2 results in flight and C_cnt=7 -> C_vld=0, C_cnt=0 before the next clock edge. After release, new pair (1,1) with op=00 -> C=0x02 and C_cnt becomes 1.
